// File: rtl/handshake_fifo_pkg.sv
// Shared defaults for the handshake FIFO slice.
// Sizes here are only the fallback parameter values.
package handshake_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 4;

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_fifo.
// One synchronous write port and a combinational read port.
module handshake_fifo_mem #(
   parameter int data_width = 32,
   parameter int depth      = 4,
   parameter int ptr_width  = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ptr_width-1:0]  waddr_i,
   input  logic [data_width-1:0] wdata_i,
   input  logic [ptr_width-1:0]  raddr_i,
   output logic [data_width-1:0] rdata_o
);

   logic [data_width-1:0] mem_q [depth];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer with request/ack-pulse handshakes on both sides
// and transfer counters for throughput measurement.
module handshake_fifo
   import handshake_fifo_pkg::*;
#(
   parameter int data_width = DEF_DATA_WIDTH,
   parameter int depth      = DEF_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        req_l,
   input  logic                        ack_l,
   input  logic [data_width-1:0]       din,
   input  logic                        req_r,
   output logic                        ack_r,
   output logic [data_width-1:0]       dout,
   output logic [$clog2(depth):0]      occupancy,
   output logic [31:0]                 count_in,
   output logic [31:0]                 count_out,
   output logic                        overflow
);

   localparam int ptr_width = $clog2(depth);
   localparam logic [ptr_width:0] FULL_OCC = (ptr_width+1)'(depth);

   logic [ptr_width-1:0]  head_q, head_d;
   logic [ptr_width-1:0]  tail_q, tail_d;
   logic [ptr_width:0]    occ_q, occ_d;
   logic                  req_l_q, req_l_d;
   logic                  ack_r_q, ack_r_d;
   logic [data_width-1:0] dout_q, dout_d;
   logic [31:0]           cin_q, cin_d;
   logic [31:0]           cout_q, cout_d;
   logic                  ovf_q, ovf_d;

   logic                  full;
   logic                  wr_en;
   logic                  pop;
   logic [data_width-1:0] rd_data;

   // Full/empty decisions use pre-edge occupancy: no bypass.
   assign full  = (occ_q == FULL_OCC);
   assign wr_en = ack_l & ~full;
   assign pop   = req_r & ~ack_r_q & (occ_q != '0);

   handshake_fifo_mem #(
      .data_width (data_width),
      .depth      (depth),
      .ptr_width  (ptr_width)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (tail_q),
      .wdata_i (din),
      .raddr_i (head_q),
      .rdata_o (rd_data)
   );

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      dout_d  = dout_q;
      cin_d   = cin_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      ack_r_d = pop;
      if (wr_en) begin
         tail_d = tail_q + 1'b1;
         cin_d  = cin_q + 32'd1;
      end
      if (ack_l && full) begin
         ovf_d = 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
         dout_d = rd_data;
         cout_d = cout_q + 32'd1;
      end
      unique case ({wr_en, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
      req_l_d = (occ_d < FULL_OCC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         req_l_q <= 1'b0;
         ack_r_q <= 1'b0;
         dout_q  <= '0;
         cin_q   <= '0;
         cout_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         req_l_q <= req_l_d;
         ack_r_q <= ack_r_d;
         dout_q  <= dout_d;
         cin_q   <= cin_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign req_l     = req_l_q;
   assign ack_r     = ack_r_q;
   assign dout      = dout_q;
   assign occupancy = occ_q;
   assign count_in  = cin_q;
   assign count_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: reset, fill, overflow, drain,
// latency, randomized stream and mid-stream reset.
module tb_handshake_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_l;
   logic        ack_l;
   logic [31:0] din;
   logic        req_r;
   logic        ack_r;
   logic [31:0] dout;
   logic [2:0]  occupancy;
   logic [31:0] count_in;
   logic [31:0] count_out;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   handshake_fifo #(.data_width(32), .depth(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_l     (req_l),
      .ack_l     (ack_l),
      .din       (din),
      .req_r     (req_r),
      .ack_r     (ack_r),
      .dout      (dout),
      .occupancy (occupancy),
      .count_in  (count_in),
      .count_out (count_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      int n = 0;
      while (!req_l && n < 10) begin
         tick();
         n++;
      end
      chk("push_req_l", 64'(req_l), 64'd1);
      ack_l = 1'b1;
      din   = v;
      tick();
      ack_l = 1'b0;
      tick();
   endtask

   task automatic take(input string tag, input logic [31:0] v);
      int n = 0;
      while (!ack_r && n < 8) begin
         tick();
         n++;
      end
      chk({tag, "_ack"}, 64'(ack_r), 64'd1);
      chk({tag, "_dout"}, 64'(dout), 64'(v));
      tick();
      chk({tag, "_pulse"}, 64'(ack_r), 64'd0);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      ack_l = 1'b0;
      req_r = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int sent;
      int rx;
      int cyc;
      rst   = 1'b1;
      ack_l = 1'b0;
      req_r = 1'b0;
      din   = '0;

      // reset with toggling inputs
      for (int i = 0; i < 2; i++) begin
         ack_l = i[0];
         req_r = ~i[0];
         din   = 32'hdead0000 + 32'(i);
         tick();
      end
      chk("rst_req_l", 64'(req_l), 64'd0);
      chk("rst_ack_r", 64'(ack_r), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_cin", 64'(count_in), 64'd0);
      chk("rst_cout", 64'(count_out), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      rst   = 1'b0;
      ack_l = 1'b0;
      req_r = 1'b0;
      tick();
      chk("rel_req_l", 64'(req_l), 64'd1);

      // fill
      for (int i = 0; i < 4; i++) push(32'(i));
      chk("fill_occ", 64'(occupancy), 64'd4);
      chk("fill_req_l", 64'(req_l), 64'd0);
      chk("fill_cin", 64'(count_in), 64'd4);
      chk("fill_ovf", 64'(overflow), 64'd0);

      // overflow while full
      ack_l = 1'b1;
      din   = 32'd99;
      tick();
      ack_l = 1'b0;
      tick();
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_occ", 64'(occupancy), 64'd4);

      // drain
      req_r = 1'b1;
      tick();
      chk("drain_first_ack", 64'(ack_r), 64'd1);
      chk("drain_first_dout", 64'(dout), 64'd0);
      chk("drain_req_l", 64'(req_l), 64'd1);
      chk("drain_occ3", 64'(occupancy), 64'd3);
      tick();
      chk("drain_gap", 64'(ack_r), 64'd0);
      for (int i = 1; i < 4; i++) take("drain", 32'(i));
      chk("drain_occ", 64'(occupancy), 64'd0);
      chk("drain_cout", 64'(count_out), 64'd4);
      repeat (3) tick();
      chk("empty_no_ack", 64'(ack_r), 64'd0);

      // latency: write at N, ack_r after N+1
      do_reset();
      chk("reset_clears_ovf", 64'(overflow), 64'd0);
      req_r = 1'b1;
      ack_l = 1'b1;
      din   = 32'h7;
      tick();
      ack_l = 1'b0;
      chk("lat_n_ack", 64'(ack_r), 64'd0);
      chk("lat_n_occ", 64'(occupancy), 64'd1);
      tick();
      chk("lat_n1_ack", 64'(ack_r), 64'd1);
      chk("lat_n1_dout", 64'(dout), 64'h7);
      chk("lat_n1_occ", 64'(occupancy), 64'd0);

      // randomized stream, consumer drops request 30% of cycles
      do_reset();
      sent = 0;
      rx   = 0;
      cyc  = 0;
      while (rx < 300 && cyc < 6000) begin
         if (ack_r) begin
            chk("stream_dout", 64'(dout), 64'(32'h1000 + 32'(rx)));
            rx++;
         end
         chk("stream_inv", 64'(count_in - count_out), 64'(occupancy));
         if (req_l && !ack_l && sent < 300) begin
            ack_l = 1'b1;
            din   = 32'h1000 + 32'(sent);
            sent++;
         end else begin
            ack_l = 1'b0;
         end
         req_r = ($urandom_range(99) >= 30);
         tick();
         cyc++;
      end
      chk("stream_done", 64'(rx), 64'd300);
      chk("stream_ovf", 64'(overflow), 64'd0);
      chk("stream_cout", 64'(count_out), 64'd300);
      ack_l = 1'b0;
      req_r = 1'b0;

      // mid-stream reset with three words stored
      do_reset();
      for (int i = 0; i < 3; i++) push(32'h200 + 32'(i));
      chk("mid_occ3", 64'(occupancy), 64'd3);
      rst = 1'b1;
      tick();
      chk("mid_occ", 64'(occupancy), 64'd0);
      chk("mid_cin", 64'(count_in), 64'd0);
      chk("mid_cout", 64'(count_out), 64'd0);
      chk("mid_req_l", 64'(req_l), 64'd0);
      rst = 1'b0;
      tick();
      push(32'h55);
      req_r = 1'b1;
      take("mid_first", 32'h55);
      req_r = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
